// File: rtl/mul_div.sv
// mul_div: multi-cycle multiply/divide unit beside the combinational ALU.
//   MLT: result = a[7:0] * b (16-bit unsigned product)
//   DIV: result = {rem, quot} of a / b, restoring, MSB-first
// Ports:
//   clk, reset_n      core clock, asynchronous active-low reset
//   start, op         request pulse (taken in IDLE/DONE), 0=MLT 1=DIV
//   a[15:0], b[7:0]   HL operand, A operand (latched on accept)
//   busy, done        operation in progress, one-cycle completion pulse
//   result[15:0]      HL write-back value
//   flags[3:0]        {S, V, C, Z}
//   div_zero          DIV with b=0, valid with done
// Build option: define MULDIV_EARLY_OUT_EN to let MUL finish as soon as
// the remaining multiplier bits are all zero.
module mul_div #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        div_zero
);

  localparam int unsigned K_MUL = 8 / BITS_PER_CYCLE;
  localparam int unsigned K_DIV = 16 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      acc_q, acc_d;       // MUL partial product
  logic [15:0]      mcand_q, mcand_d;   // MUL shifted multiplicand
  logic [7:0]       mplier_q, mplier_d; // MUL unshifted multiplier bits
  logic [15:0]      quo_q, quo_d;       // DIV dividend in, quotient out
  logic [7:0]       rem_q, rem_d;       // DIV partial remainder
  logic [7:0]       dvsr_q, dvsr_d;
  logic [15:0]      opnd_q, opnd_d;     // original HL, returned on overflow
  logic             busy_d, done_d, dz_d;
  logic [15:0]      result_d;
  logic [3:0]       flags_d;

  logic [15:0]      mul_acc, mul_mcand;
  logic [7:0]       mul_mplier;
  logic [15:0]      div_quo;
  logic [7:0]       div_rem;
  logic             mul_fin, div_fin;

  // One clock of shift-add: retire BITS_PER_CYCLE multiplier bits
  always_comb begin : mul_step
    mul_acc = acc_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier_q[i]) mul_acc = mul_acc + (mcand_q << i);
    end
    mul_mcand  = mcand_q << BITS_PER_CYCLE;
    mul_mplier = mplier_q >> BITS_PER_CYCLE;
  end

  // One clock of restoring division; the 9-bit shifted remainder keeps the
  // carry out of bit 7 so the compare never loses it
  always_comb begin : div_step
    logic [8:0] rsh;
    rsh     = '0;
    div_quo = quo_q;
    div_rem = rem_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      rsh     = {div_rem, div_quo[15]};
      div_quo = {div_quo[14:0], 1'b0};
      if (rsh >= {1'b0, dvsr_q}) begin
        rsh        = rsh - {1'b0, dvsr_q};
        div_quo[0] = 1'b1;
      end
      div_rem = rsh[7:0];
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_fin = (cnt_q == CNT_W'(K_MUL - 1)) || (mul_mplier == 8'h00);
`else
  assign mul_fin = (cnt_q == CNT_W'(K_MUL - 1));
`endif
  assign div_fin = (cnt_q == CNT_W'(K_DIV - 1));

  // Next state, datapath updates and registered outputs
  always_comb begin : fsm_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    opnd_d   = opnd_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dz_d     = div_zero;
    result_d = result;
    flags_d  = flags;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dz_d     = 1'b0;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {8'h00, a[7:0]};
          mplier_d = b;
          quo_d    = a;
          rem_d    = '0;
          dvsr_d   = b;
          opnd_d   = a;
          if (!op) begin
`ifdef MULDIV_EARLY_OUT_EN
            if (b == 8'h00) begin
              state_d  = DONE;
              done_d   = 1'b1;
              result_d = '0;
              flags_d  = 4'b0001;
            end else begin
              state_d = MUL;
              busy_d  = 1'b1;
            end
`else
            state_d = MUL;
            busy_d  = 1'b1;
`endif
          end else if (b == 8'h00) begin
            state_d  = DONE;
            done_d   = 1'b1;
            dz_d     = 1'b1;
            result_d = a;
            flags_d  = '0;
          end else begin
            state_d = DIV;
            busy_d  = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = mul_acc;
        mcand_d  = mul_mcand;
        mplier_d = mul_mplier;
        cnt_d    = cnt_q + CNT_W'(1);
        busy_d   = 1'b1;
        if (mul_fin) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = mul_acc;
          flags_d  = {mul_acc[15], 2'b00, (mul_acc == 16'h0000)};
        end
      end
      DIV: begin
        quo_d  = div_quo;
        rem_d  = div_rem;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (div_fin) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (div_quo[15:8] != 8'h00) begin
            result_d = opnd_q;
            flags_d  = 4'b0100;
          end else begin
            result_d = {div_rem, div_quo[7:0]};
            flags_d  = {div_quo[7], 2'b00, (div_quo[7:0] == 8'h00)};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin : regs
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      opnd_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      opnd_q   <= opnd_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= dz_d;
      result   <= result_d;
      flags    <= flags_d;
    end
  end

endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: self-checking bench for mul_div (BITS_PER_CYCLE=1) against a
// plain-arithmetic reference model; directed cases then random operations.
module tb_mul_div;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  b = '0;
  logic        busy, done, div_zero;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  mul_div #(.BITS_PER_CYCLE(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flags    (flags),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result, flags {S,V,C,Z}, div_zero and cycles from accept to done
  function automatic void model(input logic o, input logic [15:0] aa, input logic [7:0] bb,
                                output logic [15:0] r, output logic [3:0] f,
                                output logic dz, output int lat);
    int p, q, m;
    dz = 1'b0;
    if (!o) begin
      p   = int'(aa[7:0]) * int'(bb);
      r   = 16'(p);
      f   = {r[15], 2'b00, (p == 0)};
      lat = 9;
`ifdef MULDIV_EARLY_OUT_EN
      for (int i = 8; i >= 0; i--) if ((int'(bb) >> i) == 0) lat = 1 + i;
`endif
    end else if (bb == 8'h00) begin
      r = aa; f = 4'b0000; dz = 1'b1; lat = 1;
    end else begin
      q   = int'(aa) / int'(bb);
      m   = int'(aa) % int'(bb);
      lat = 17;
      if (q > 255) begin
        r = aa; f = 4'b0100;
      end else begin
        r = {8'(m), 8'(q)};
        f = {r[7], 2'b00, (q == 0)};
      end
    end
  endfunction

  // Issue one operation, scramble inputs after acceptance, optionally pulse
  // an ignored start mid-operation, then check timing and results
  task automatic do_op(input logic o, input logic [15:0] aa, input logic [7:0] bb, input bit inject);
    logic [15:0] er;
    logic [3:0]  ef;
    logic        edz;
    int          el;
    int          lat;
    bit          busy_bad;
    model(o, aa, bb, er, ef, edz, el);
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = 16'($urandom); b = 8'($urandom);
    check("dz_after_start", 32'(div_zero), 32'(edz));
    lat = 1;
    busy_bad = 1'b0;
    while (!done && lat < 40) begin
      start = inject && (lat == 3);
      if (!busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(el));
    check("busy_during_op", 32'(busy_bad), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    check("result", 32'(result), 32'(er));
    check("flags", 32'(flags), 32'(ef));
    check("div_zero", 32'(div_zero), 32'(edz));
  endtask

  initial begin : stim
    logic [7:0]  rb;
    logic [15:0] ra;
    logic        ro;
    bit          done_seen;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_op(1'b0, 16'h000C, 8'h0B, 1'b0);
    do_op(1'b0, 16'h00FF, 8'hFF, 1'b0);
    do_op(1'b0, 16'h0000, 8'h37, 1'b0);
    do_op(1'b0, 16'h5A5A, 8'h00, 1'b0);
    do_op(1'b0, 16'hFF01, 8'h01, 1'b1);
    do_op(1'b0, 16'h0080, 8'h80, 1'b0);
    do_op(1'b1, 16'h1234, 8'h56, 1'b1);
    do_op(1'b1, 16'h1234, 8'h02, 1'b0);
    do_op(1'b1, 16'h0005, 8'h07, 1'b0);
    do_op(1'b1, 16'h1234, 8'h00, 1'b0);
    do_op(1'b0, 16'h0003, 8'h04, 1'b0);
    do_op(1'b1, 16'hFFFF, 8'hFF, 1'b0);
    do_op(1'b1, 16'hFEFF, 8'hFF, 1'b0);
    do_op(1'b1, 16'hABCD, 8'h00, 1'b0);
    do_op(1'b1, 16'hABCD, 8'h00, 1'b0);
    do_op(1'b1, 16'h00FF, 8'h01, 1'b0);

    // Abort a DIV with reset: outputs clear at once and no done follows
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 16'h1234; b = 8'h56;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    do_op(1'b0, 16'h0003, 8'h04, 1'b0);

    // Random operations with random idle gaps (gap 0 = back-to-back in DONE)
    for (int n = 0; n < 300; n++) begin
      ro = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 8'h00;
        1:       rb = 8'($urandom_range(1, 3));
        default: rb = 8'($urandom);
      endcase
      ra = 16'($urandom);
      if (ro && rb != 8'h00 && $urandom_range(0, 1) == 1)
        ra = {8'($urandom_range(0, int'(rb) - 1)), 8'($urandom)};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(ro, ra, rb, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_div.md
Name: mul_div

Overview:
- Multi-cycle multiply/divide unit for the S1C88 core, beside the single-cycle combinational ALU.
- Executes MLT (L × A → HL) and DIV (HL ÷ A → L quotient, H remainder).
- The microcode sequencer issues a start pulse, waits for done, then writes back result and flags using the same flag-bit layout as the ALU.

Parameters:
BITS_PER_CYCLE, 1, iterations retired per clock; legal values 1, 2, 4. K_MUL = 8/BITS_PER_CYCLE; K_DIV = 16/BITS_PER_CYCLE.

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when busy=0
op  input  1  0=MLT, 1=DIV
a  input  16  HL operand; MLT uses a[7:0] as multiplicand
b  input  8  A operand: multiplier or divisor
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
result  output  16  HL write-back value
flags  output  4  bit0 Z, bit1 C, bit2 V, bit3 S
div_zero  output  1  DIV with b=0; valid with done

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, div_zero, result, flags all 0. Takes effect mid-operation; the aborted operation produces no done.
- States:
  - IDLE: start → MUL (op=0), DIV (op=1, b≠0) or DONE (op=1, b=0).
  - MUL: runs K_MUL cycles → DONE.
  - DIV: runs K_DIV cycles → DONE.
  - DONE: → IDLE.
- busy=1 only in MUL/DIV. start is accepted in IDLE or DONE (back-to-back allowed); start while busy is ignored.
- Operands are latched on the accepting edge; later changes to a/b/op have no effect.
- Timing: start accepted at edge N → busy from cycle N+1; done=1 for exactly cycle N+1+K (K=K_MUL or K_DIV). Div-by-zero: done at N+1.
- result/flags/div_zero update with done and hold until the next accepted start; div_zero clears on that start.
- MLT: radix-2^BITS_PER_CYCLE shift-add, LSB-first over b; 16-bit unsigned product.
  - result = a[7:0]*b.
  - Z = (result==0), S = result[15], C=0, V=0.
- DIV: restoring unsigned 16÷8, MSB-first, 9-bit partial remainder (no carry loss).
  - Quotient ≤ 0xFF: result = {rem[7:0], quot[7:0]}; Z = (quot[7:0]==0), S = quot[7], C=0, V=0.
  - Quotient > 0xFF (overflow): result = a unchanged; V=1, Z=0, S=0, C=0.
  - b=0: div_zero=1, result = a, flags=0.
- All arithmetic is unsigned; no sign extension of operands.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: MUL exits to DONE on the cycle after the remaining unshifted multiplier bits become zero (b=0 → done at N+1; b=0x01 with BITS_PER_CYCLE=1 → done at N+2). DIV timing is unchanged.
- Undefined: MUL always takes exactly K_MUL cycles. Results and flags are identical either way.

Test Plan (BITS_PER_CYCLE=1; start accepted at edge N):
1. MLT a=0x000C, b=0x0B → done at N+9, result=0x0084, flags Z=0 S=0 C=0 V=0; busy high N+1..N+8.
2. MLT a=0x00FF, b=0xFF → result=0xFE01, S=1, Z=0. Then a=0x0000, b=0x37 → result=0x0000, Z=1. Early-out build: b=0x00 gives done at N+1.
3. DIV a=0x1234, b=0x56 → done at N+17, result=0x1036 (quot 0x36, rem 0x10), Z=0, S=0, V=0.
4. DIV a=0x1234, b=0x02 → quotient 0x91A overflows: V=1, result=0x1234. Then DIV a=0x0005, b=0x07 → result=0x0500, Z=1.
5. DIV a=0x1234, b=0x00 → done at N+1, div_zero=1, result=0x1234, flags=0; next accepted start clears div_zero.
6. Start DIV, pulse start again at N+3 (ignored), drop reset_n at N+5 → busy/done/result/flags=0 immediately, no done pulse. After release, MLT 0x0003×0x04 → 0x000C. Back-to-back start during the DONE cycle is accepted.
